// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage PC sequencer with pending-redirect buffering and halt
// Decides PC load enable/value each cycle; redirects seen during an outstanding fetch wait for ihit.
module pc_sequencer #(
  parameter int                WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              hz_stall,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  input  logic              jmp_valid,
  input  logic [WORD_W-1:0] jmp_target,
  input  logic              halt_in,
  input  logic [WORD_W-1:0] npc,
  output logic              pc_en,
  output logic [WORD_W-1:0] new_pc,
  output logic              imem_ren,
  output logic              flush_ifid,
  output logic              flush_idex,
  output logic              halted
);

  typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

  state_t            state, state_nx;
  logic [WORD_W-1:0] pend_target, pend_target_nx;
  logic              pend_is_br, pend_is_br_nx;
  logic              redir;
  logic [WORD_W-1:0] redir_target;

  // The branch belongs to the older instruction, so it wins over a same-cycle jump.
  assign redir        = br_taken | jmp_valid;
  assign redir_target = br_taken ? br_target : jmp_target;

  always_comb begin
    state_nx       = state;
    pend_target_nx = pend_target;
    pend_is_br_nx  = pend_is_br;
    pc_en          = 1'b0;
    new_pc         = npc;
    imem_ren       = 1'b1;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    halted         = 1'b0;
    case (state)
      RUN: begin
        if (halt_in) begin
          state_nx = HALT;
          imem_ren = 1'b0;
          halted   = 1'b1;
        end else if (redir) begin
          flush_ifid = 1'b1;
          flush_idex = br_taken;
          if (ihit) begin
            pc_en  = 1'b1;
            new_pc = redir_target;
          end else begin
            pend_target_nx = redir_target;
            pend_is_br_nx  = br_taken;
            state_nx       = PEND;
          end
        end else begin
          pc_en = ihit & ~hz_stall;
        end
      end
      PEND: begin
        if (halt_in) begin
          state_nx = HALT;
          imem_ren = 1'b0;
          halted   = 1'b1;
        end else begin
          if (br_taken) begin
            pend_target_nx = br_target;
            pend_is_br_nx  = 1'b1;
            flush_ifid     = 1'b1;
            flush_idex     = 1'b1;
          end else if (jmp_valid && !pend_is_br) begin
            pend_target_nx = jmp_target;
          end
          // Fetch returned: load the (possibly just overridden) target and drop the stale instruction.
          if (ihit) begin
            pc_en      = 1'b1;
            new_pc     = pend_target_nx;
            flush_ifid = 1'b1;
            state_nx   = RUN;
          end
        end
      end
      HALT: begin
        imem_ren = 1'b0;
        halted   = 1'b1;
      end
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= RUN;
      pend_target <= PC_INIT;
      pend_is_br  <= 1'b0;
    end else begin
      state       <= state_nx;
      pend_target <= pend_target_nx;
      pend_is_br  <= pend_is_br_nx;
    end
  end

endmodule
